// File: rtl/voxel_world_memory_pkg.sv
// Shared voxel types, FSM state enum and world-index helpers for the voxel world memory.
package voxel_world_memory_pkg;

    localparam int unsigned COORD_W   = 8;
    localparam int unsigned IDX_W_MAX = 3 * COORD_W;

    typedef enum logic [3:0] {
        BLOCK_AIR   = 4'd0,
        BLOCK_STONE = 4'd1,
        BLOCK_DIRT  = 4'd2,
        BLOCK_GRASS = 4'd3,
        BLOCK_WATER = 4'd4,
        BLOCK_SAND  = 4'd5
    } BlockType;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } BlockPos;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CLEAR = 2'd2
    } WorldMemState;

    function automatic logic in_range(input logic signed [COORD_W-1:0] c, input int unsigned bits);
        return (int'(c) >= 0) && (int'(c) < (1 << bits));
    endfunction

    function automatic logic in_world(input BlockPos p, input int unsigned xb,
                                      input int unsigned yb, input int unsigned zb);
        return in_range(p.x, xb) && in_range(p.y, yb) && in_range(p.z, zb);
    endfunction

    // Linear index {z, y, x} using the low bits of each coordinate.
    function automatic logic [IDX_W_MAX-1:0] block_index(input BlockPos p, input int unsigned xb,
                                                         input int unsigned yb, input int unsigned zb);
        logic [IDX_W_MAX-1:0] xi;
        logic [IDX_W_MAX-1:0] yi;
        logic [IDX_W_MAX-1:0] zi;
        xi = IDX_W_MAX'(p.x) & ((IDX_W_MAX'(1) << xb) - IDX_W_MAX'(1));
        yi = IDX_W_MAX'(p.y) & ((IDX_W_MAX'(1) << yb) - IDX_W_MAX'(1));
        zi = IDX_W_MAX'(p.z) & ((IDX_W_MAX'(1) << zb) - IDX_W_MAX'(1));
        return (zi << (xb + yb)) | (yi << xb) | xi;
    endfunction

endpackage

// File: rtl/voxel_world_memory_if.sv
// Voxel read bus plus loader write/clear controls between requester (master) and world memory (slave).
interface voxel_world_memory_if;
    import voxel_world_memory_pkg::*;

    BlockPos  ram_addr;
    logic     ram_read_enable;
    BlockType ram_out;
    logic     ram_valid;
    logic     wr_en;
    BlockPos  wr_addr;
    BlockType wr_data;
    logic     clear_start;
    logic     clear_busy;

    modport master (
        output ram_addr, ram_read_enable, wr_en, wr_addr, wr_data, clear_start,
        input  ram_out, ram_valid, clear_busy
    );

    modport slave (
        input  ram_addr, ram_read_enable, wr_en, wr_addr, wr_data, clear_start,
        output ram_out, ram_valid, clear_busy
    );

endinterface

// File: rtl/voxel_world_memory_bram.sv
// Simple dual-port read-first block RAM with a RAM_LATENCY-deep read pipeline.
module voxel_world_memory_bram #(
    parameter int unsigned DEPTH_BITS  = 14,
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned RAM_LATENCY = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned DEPTH  = 1 << DEPTH_BITS;
    localparam int unsigned PIPE_W = RAM_LATENCY * WIDTH;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PIPE_W-1:0] pipe_q;

    // Contents are loaded through the write port or a clear sweep; file preload has no hardware path.
    if (INIT_FILE != "") begin : g_init_check
        $error("voxel_world_memory_bram: INIT_FILE preload unsupported, load through the write port");
    end

    // Stage 0 (LSBs) captures the array read; read-first on same-address write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        pipe_q <= (pipe_q << WIDTH) | PIPE_W'(mem_q[raddr_i]);
    end

    assign rdata_o = pipe_q[PIPE_W-1 -: WIDTH];

endmodule

// File: rtl/voxel_world_memory.sv
// Voxel world memory: single-outstanding read responder, loader write port and clear-world sweep.
module voxel_world_memory
    import voxel_world_memory_pkg::*;
#(
    parameter int unsigned X_BITS      = 5,
    parameter int unsigned Y_BITS      = 4,
    parameter int unsigned Z_BITS      = 5,
    parameter int unsigned RAM_LATENCY = 2,
    parameter string       INIT_FILE   = ""
) (
    input logic                 clk_in,
    input logic                 rst_in,
    voxel_world_memory_if.slave bus
);

    localparam int unsigned IDX_W    = X_BITS + Y_BITS + Z_BITS;
    localparam int unsigned LAST_IDX = (1 << IDX_W) - 1;
    localparam int unsigned CNT_W    = $clog2(RAM_LATENCY + 1);
    localparam int unsigned BT_W     = $bits(BlockType);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_CLEAR = CLEAR;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [IDX_W-1:0] clr_q, clr_d;
    logic             inb_q, inb_d;
    BlockType         out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [IDX_W-1:0] rd_idx_c;
    logic             rd_inb_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic             wr_inb_c;
    logic             bram_we_c;
    logic [IDX_W-1:0] bram_waddr_c;
    logic [BT_W-1:0]  bram_wdata_c;
    logic [BT_W-1:0]  bram_rdata_c;

    assign rd_idx_c = IDX_W'(block_index(bus.ram_addr, X_BITS, Y_BITS, Z_BITS));
    assign rd_inb_c = in_world(bus.ram_addr, X_BITS, Y_BITS, Z_BITS);
    assign wr_idx_c = IDX_W'(block_index(bus.wr_addr, X_BITS, Y_BITS, Z_BITS));
    assign wr_inb_c = in_world(bus.wr_addr, X_BITS, Y_BITS, Z_BITS);

    // Sweep owns the write port while clearing; external writes are dropped then.
    always_comb begin
        bram_we_c    = bus.wr_en && wr_inb_c;
        bram_waddr_c = wr_idx_c;
        bram_wdata_c = bus.wr_data;
        if (state_q == ST_CLEAR) begin
            bram_we_c    = 1'b1;
            bram_waddr_c = clr_q;
            bram_wdata_c = BLOCK_AIR;
        end
    end

    voxel_world_memory_bram #(
        .DEPTH_BITS  (IDX_W),
        .WIDTH       (BT_W),
        .RAM_LATENCY (RAM_LATENCY),
        .INIT_FILE   (INIT_FILE)
    ) u_bram (
        .clk_i   (clk_in),
        .we_i    (bram_we_c),
        .waddr_i (bram_waddr_c),
        .wdata_i (bram_wdata_c),
        .raddr_i (rd_idx_c),
        .rdata_o (bram_rdata_c)
    );

    // Next-state: READ captures data at count RAM_LATENCY-1 and holds off reissue one more cycle.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        clr_d   = clr_q;
        inb_d   = inb_q;
        out_d   = out_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        if (bus.clear_start && !busy_q) begin
            state_d = ST_CLEAR;
            clr_d   = '0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ram_read_enable) begin
                        state_d = ST_READ;
                        lat_d   = '0;
                        inb_d   = rd_inb_c;
                    end
                end
                ST_READ: begin
                    if (!bus.ram_read_enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (lat_q == CNT_W'(RAM_LATENCY - 1)) begin
                            out_d   = inb_q ? BlockType'(bram_rdata_c) : BLOCK_AIR;
                            valid_d = 1'b1;
                        end
                        if (lat_q == CNT_W'(RAM_LATENCY)) begin
                            state_d = ST_IDLE;
                        end else begin
                            lat_d = lat_q + CNT_W'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    if (clr_q == IDX_W'(LAST_IDX)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        clr_d = clr_q + IDX_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            clr_q   <= '0;
            inb_q   <= 1'b0;
            out_q   <= BLOCK_AIR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            clr_q   <= clr_d;
            inb_q   <= inb_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ram_out    = out_q;
    assign bus.ram_valid  = valid_q;
    assign bus.clear_busy = busy_q;

endmodule

// File: tb/tb_voxel_world_memory.sv
// Directed + randomized bench for voxel_world_memory against an array model of the world.
module tb_voxel_world_memory;
    import voxel_world_memory_pkg::*;

    localparam int unsigned XB = 5;
    localparam int unsigned YB = 4;
    localparam int unsigned ZB = 5;
    localparam int unsigned LAT = 2;
    localparam int WORLD = 1 << (XB + YB + ZB);

    logic clk;
    logic rst;
    int total;
    int bad;
    BlockType model_mem [WORLD];

    voxel_world_memory_if bus ();

    voxel_world_memory #(
        .X_BITS      (XB),
        .Y_BITS      (YB),
        .Z_BITS      (ZB),
        .RAM_LATENCY (LAT),
        .INIT_FILE   ("")
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic BlockPos mkpos(input int x, input int y, input int z);
        BlockPos p;
        p.x = 8'(x);
        p.y = 8'(y);
        p.z = 8'(z);
        return p;
    endfunction

    function automatic bit model_inb(input BlockPos p);
        int x;
        int y;
        int z;
        x = int'(p.x);
        y = int'(p.y);
        z = int'(p.z);
        return x >= 0 && x < 32 && y >= 0 && y < 16 && z >= 0 && z < 32;
    endfunction

    function automatic int model_idx(input BlockPos p);
        return int'(p.x) + 32 * int'(p.y) + 512 * int'(p.z);
    endfunction

    function automatic BlockType model_read(input BlockPos p);
        if (!model_inb(p)) return BLOCK_AIR;
        return model_mem[model_idx(p)];
    endfunction

    task automatic model_write(input BlockPos p, input BlockType d);
        if (model_inb(p)) model_mem[model_idx(p)] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < WORLD; i++) model_mem[i] = BLOCK_AIR;
    endtask

    task automatic do_write(input BlockPos p, input BlockType d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = p;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        model_write(p, d);
    endtask

    // Single read; optional write issued in the same cycle as the read.
    task automatic read_check(input string tag, input BlockPos p, input bit do_wr,
                              input BlockPos wp, input BlockType wd);
        BlockType exp;
        BlockType got;
        int first_k;
        int strobes;
        exp = model_read(p);
        @(negedge clk);
        bus.ram_addr        = p;
        bus.ram_read_enable = 1'b1;
        if (do_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = wp;
            bus.wr_data = wd;
            model_write(wp, wd);
        end
        first_k = 0;
        strobes = 0;
        got     = BLOCK_AIR;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.wr_en = 1'b0;
            if (bus.ram_valid) begin
                strobes++;
                if (first_k == 0) begin
                    first_k = k;
                    got     = bus.ram_out;
                end
            end
            if (k == 3) bus.ram_read_enable = 1'b0;
        end
        check({tag, "_lat"}, first_k, LAT + 1);
        check({tag, "_cnt"}, strobes, 1);
        check({tag, "_val"}, got, exp);
    endtask

    task automatic run_clear(input string tag, input bit distract);
        int n;
        @(negedge clk);
        bus.clear_start = 1'b1;
        @(negedge clk);
        bus.clear_start = 1'b0;
        n = 0;
        while (bus.clear_busy && n < 20000) begin
            n++;
            if (distract && n == 5000) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = mkpos(0, 0, 0);
                bus.wr_data = BLOCK_STONE;
            end
            if (n == 5001) bus.wr_en = 1'b0;
            if (distract && n == 8000) bus.clear_start = 1'b1;
            if (n == 8001) bus.clear_start = 1'b0;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, n, WORLD);
        model_clear();
    endtask

    initial begin
        BlockPos p;
        BlockPos wp;
        BlockType wd;
        int x;
        int strobes;
        int cyc;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.ram_addr        = mkpos(0, 0, 0);
        bus.ram_read_enable = 1'b0;
        bus.wr_en           = 1'b0;
        bus.wr_addr         = mkpos(0, 0, 0);
        bus.wr_data         = BLOCK_AIR;
        bus.clear_start     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.ram_valid, 0);
        check("rst_busy", bus.clear_busy, 0);
        check("rst_out", bus.ram_out, BLOCK_AIR);
        rst = 1'b0;

        run_clear("clr0", 1'b0);

        // Held request: strobes every RAM_LATENCY+2 cycles, first at RAM_LATENCY+1.
        do_write(mkpos(3, 2, 5), BLOCK_STONE);
        do_write(mkpos(4, 0, 0), BLOCK_STONE);
        @(negedge clk);
        bus.ram_addr        = mkpos(3, 2, 5);
        bus.ram_read_enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("hold_valid_c%0d", k), bus.ram_valid, (k % 4) == 3);
            if (bus.ram_valid) check($sformatf("hold_out_c%0d", k), bus.ram_out, BLOCK_STONE);
        end
        bus.ram_read_enable = 1'b0;
        @(negedge clk);

        // Stepping requester along x on each strobe.
        x = 0;
        strobes = 0;
        cyc = 0;
        bus.ram_addr        = mkpos(0, 0, 0);
        bus.ram_read_enable = 1'b1;
        while (strobes < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.ram_valid) begin
                check($sformatf("step%0d_cyc", strobes), cyc, 3 + 4 * strobes);
                check($sformatf("step%0d_val", strobes), bus.ram_out, model_read(mkpos(x, 0, 0)));
                strobes++;
                x++;
                bus.ram_addr = mkpos(x, 0, 0);
                if (strobes == 5) bus.ram_read_enable = 1'b0;
            end
        end
        bus.ram_read_enable = 1'b0;
        check("step_strobes", strobes, 5);

        // Out-of-bounds reads, aliasing targets filled with stone.
        do_write(mkpos(0, 0, 0), BLOCK_STONE);
        do_write(mkpos(31, 0, 0), BLOCK_STONE);
        read_check("oob_neg", mkpos(-1, 0, 0), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        read_check("oob_pos", mkpos(32, 0, 0), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        read_check("alias0", mkpos(0, 0, 0), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        read_check("alias31", mkpos(31, 0, 0), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);

        // Collision: write in issue cycle is read-first.
        check("coll_pre", model_read(mkpos(1, 1, 1)), BLOCK_AIR);
        read_check("coll_old", mkpos(1, 1, 1), 1'b1, mkpos(1, 1, 1), BLOCK_DIRT);
        read_check("coll_new", mkpos(1, 1, 1), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        do_write(mkpos(0, 16, 0), BLOCK_GRASS);
        read_check("oob_wr", mkpos(0, 0, 0), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);

        // Abort: enable dropped one cycle after issue.
        @(negedge clk);
        bus.ram_addr        = mkpos(3, 2, 5);
        bus.ram_read_enable = 1'b1;
        @(negedge clk);
        bus.ram_read_enable = 1'b0;
        strobes = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.ram_valid) strobes++;
            @(negedge clk);
        end
        check("abort_strobes", strobes, 0);
        read_check("after_abort", mkpos(3, 2, 5), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);

        // Randomized writes and reads against the model.
        for (int i = 0; i < 30; i++) begin
            wp = mkpos(int'($urandom_range(0, 39)) - 4, int'($urandom_range(0, 19)) - 2,
                       int'($urandom_range(0, 35)) - 2);
            wd = BlockType'(4'($urandom_range(0, 5)));
            do_write(wp, wd);
            if ($urandom_range(0, 1) == 0) p = wp;
            else p = mkpos(int'($urandom_range(0, 39)) - 4, int'($urandom_range(0, 19)) - 2,
                           int'($urandom_range(0, 35)) - 2);
            read_check($sformatf("rnd%0d", i), p, 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        end

        // Clear with ignored write and ignored restart, then world must read as air.
        run_clear("clr1", 1'b1);
        read_check("clr_a", mkpos(3, 2, 5), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        read_check("clr_b", mkpos(4, 0, 0), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        read_check("clr_c", mkpos(1, 1, 1), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        read_check("clr_d", mkpos(0, 0, 0), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        for (int i = 0; i < 6; i++) begin
            p = mkpos(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
            read_check($sformatf("clr_rnd%0d", i), p, 1'b0, mkpos(0, 0, 0), BLOCK_AIR);
        end

        // Reset mid-sweep: busy drops next cycle, unreached voxels keep their data.
        do_write(mkpos(7, 7, 7), BLOCK_SAND);
        @(negedge clk);
        bus.clear_start = 1'b1;
        @(negedge clk);
        bus.clear_start = 1'b0;
        check("mid_busy_on", bus.clear_busy, 1);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", bus.clear_busy, 0);
        check("mid_rst_valid", bus.ram_valid, 0);
        rst = 1'b0;
        read_check("mid_keep", mkpos(7, 7, 7), 1'b0, mkpos(0, 0, 0), BLOCK_AIR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
